uart_rx_axis: RTL and testbench

UART receiver that deserialises an asynchronous 8N1-style serial line and presents received bytes as an AXI-Stream master through a small first-word-fall-through FIFO. It is the receive-side counterpart to the AXI-Stream-to-UART transmitter in the `top_axis_uart` path, and loops the transmitter's `uart_tx` back into a stream for downstream consumers. It detects framing errors and FIFO overrun and reports each as a single-cycle pulse.

---
 rtl/uart_rx_axis_if.sv | 9 +
 rtl/uart_rx_axis.sv | 89 ++++++++
 tb/tb_uart_rx_axis.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_axis_if.sv
// uart_rx_axis_if: AXI-Stream byte channel carrying received UART data
// Ports: data/valid driven by the master (receiver), ready driven by the slave (consumer)
interface uart_rx_axis_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 8N1-style UART receiver feeding an AXI-Stream master through a FWFT FIFO
// Ports: clk, rst_n (async active-low), uart_rx (serial in, idles high),
//        m_axis (master: data = FIFO head, valid = FIFO not empty, ready from consumer),
//        frame_err (1-cycle pulse, stop bit sampled 0), overrun (1-cycle pulse, good byte dropped on full FIFO)
module uart_rx_axis #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uart_rx,
    uart_rx_axis_if.master   m_axis,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    state_t               state;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wptr, rptr;
    logic                 cnt_half, cnt_end, full, empty, pop, push_req, push;
    assign cnt_half = cnt == CW'(CLKS_PER_BIT/2 - 1);
    assign cnt_end  = cnt == CW'(CLKS_PER_BIT - 1);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty    = wptr == rptr;
    assign pop      = m_axis.valid && m_axis.ready;
    assign push_req = state == STOP && cnt_end && rx_s;
    // a full FIFO still takes the byte when the head leaves in the same cycle
    assign push     = push_req && (!full || pop);
    assign m_axis.valid = !empty;
    assign m_axis.data  = mem[rptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            rx_meta   <= uart_rx;
            rx_s      <= rx_meta;
            frame_err <= 1'b0;
            overrun   <= push_req && !push;
            if (push) begin
                mem[wptr[AW-1:0]] <= shreg;
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop) rptr <= rptr + (AW+1)'(1);
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (cnt_half) begin
                    state <= rx_s ? IDLE : DATA;
                    cnt   <= '0;
                    idx   <= '0;
                end else cnt <= cnt + CW'(1);
                DATA: if (cnt_end) begin
                    shreg[idx] <= rx_s;
                    cnt        <= '0;
                    idx        <= idx + IW'(1);
                    if (idx == IW'(DATA_BITS - 1)) state <= STOP;
                end else cnt <= cnt + CW'(1);
                STOP: if (cnt_end) begin
                    cnt       <= '0;
                    state     <= rx_s ? IDLE : WAIT_IDLE;
                    frame_err <= !rx_s;
                end else cnt <= cnt + CW'(1);
                // a held-low line stays here so a break reports only one framing error
                WAIT_IDLE: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: scoreboard bench for the UART receiver with AXI-Stream output
module tb_uart_rx_axis;
    logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
    logic frame_err, overrun;
    uart_rx_axis_if #(.DATA_BITS(8)) m_axis();
    uart_rx_axis #(.DATA_BITS(8), .CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .m_axis(m_axis),
        .frame_err(frame_err), .overrun(overrun)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0, cyc = 0, frame_cyc = 0, pop_cyc = 0;
    int valid_cycles = 0, fe_seen = 0, ov_seen = 0;
    logic [7:0] exp_q[$];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis.valid) valid_cycles++;
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            if (m_axis.valid && m_axis.ready) begin
                pop_cyc = cyc;
                if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, m_axis.data}, 32'hFFFF_FFFF);
                else chk("rx_byte", {24'd0, m_axis.data}, {24'd0, exp_q.pop_front()});
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        frame_cyc = cyc;
        uart_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(16);
        end
        uart_rx = stop_bit;
        tick(16);
    endtask
    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        chk(name, exp_q.size(), 0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int vc0, fe0, ov0;
        logic [7:0] four [4];
        m_axis.ready = 1'b0;
        tick(3);
        chk("reset_valid", m_axis.valid, 0);
        chk("reset_data", m_axis.data, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(3);
        // single byte, consumer always ready
        m_axis.ready = 1'b1;
        vc0 = valid_cycles; fe0 = fe_seen; ov0 = ov_seen;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(4);
        chk("single_latency", pop_cyc - frame_cyc, 155);
        chk("single_valid_cycles", valid_cycles - vc0, 1);
        chk("single_no_err", fe_seen - fe0 + ov_seen - ov0, 0);
        chk("single_drained", exp_q.size(), 0);
        // back-to-back with backpressure, then overrun
        m_axis.ready = 1'b0;
        ov0 = ov_seen;
        four = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(four[i]);
            send_frame(four[i], 1'b1);
        end
        tick(4);
        chk("full_valid", m_axis.valid, 1);
        chk("full_head", m_axis.data, 8'h01);
        send_frame(8'h55, 1'b1);
        tick(4);
        chk("overrun_pulses", ov_seen - ov0, 1);
        chk("full_head_held", m_axis.data, 8'h01);
        m_axis.ready = 1'b1;
        drain("b2b_drain");
        tick(4);
        chk("b2b_empty", m_axis.valid, 0);
        // framing error followed by a long break
        fe0 = fe_seen;
        send_frame(8'h3C, 1'b0);
        tick(640);
        chk("break_one_frame_err", fe_seen - fe0, 1);
        chk("break_no_valid", m_axis.valid, 0);
        uart_rx = 1'b1;
        tick(32);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        tick(4);
        drain("after_break_drain");
        chk("after_break_frame_err", fe_seen - fe0, 1);
        // start-bit glitch
        vc0 = valid_cycles; fe0 = fe_seen; ov0 = ov_seen;
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(40);
        chk("glitch_no_valid", valid_cycles - vc0, 0);
        chk("glitch_no_err", fe_seen - fe0 + ov_seen - ov0, 0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        tick(4);
        drain("glitch_recover_drain");
        // reset during data bit 3 of 0xFF
        uart_rx = 1'b0;
        tick(16);
        uart_rx = 1'b1;
        tick(56);
        rst_n = 1'b0;
        tick(2);
        chk("midreset_valid", m_axis.valid, 0);
        chk("midreset_data", m_axis.data, 0);
        chk("midreset_frame_err", frame_err, 0);
        chk("midreset_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(20);
        vc0 = valid_cycles;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        tick(4);
        drain("midreset_drain");
        chk("midreset_one_byte", valid_cycles - vc0, 1);
        // full FIFO with a pop coinciding with the stop sample
        m_axis.ready = 1'b0;
        ov0 = ov_seen;
        four = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(four[i]);
            send_frame(four[i], 1'b1);
        end
        tick(4);
        chk("full2_valid", m_axis.valid, 1);
        exp_q.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1);
            begin
                tick(154);
                m_axis.ready = 1'b1;
                tick(1);
                m_axis.ready = 1'b0;
            end
        join
        tick(4);
        chk("simul_no_overrun", ov_seen - ov0, 0);
        chk("simul_head", m_axis.data, 8'h22);
        chk("simul_queue_left", exp_q.size(), 4);
        m_axis.ready = 1'b1;
        drain("simul_drain");
        tick(4);
        chk("final_empty", m_axis.valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
